// File: rtl/timer_array.sv
// Bank of N_CH independent down-counting timers behind one register port.
// Each channel: CTRL {PEND,IM,MODE,EN}, PRESET, read-only COUNT; irq = PEND & IM.
module timer_array #(
  parameter int N_CH  = 2,
  parameter int CNT_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [7:0]      addr,
  input  logic            we,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  output logic [N_CH-1:0] irq,
  output logic            irq_any
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_CNT  = 2'd2;
  localparam logic [1:0] ST_INT  = 2'd3;

  localparam logic [1:0] R_CTRL   = 2'd0;
  localparam logic [1:0] R_PRESET = 2'd1;
  localparam logic [1:0] R_COUNT  = 2'd2;

  logic [N_CH-1:0][31:0] rd_ch;
  logic                  unused_bits;

  assign unused_bits = ^{addr[7], addr[1:0], wdata[31:4]};

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic             en_reg, mode_reg, im_reg, pend_reg;
      logic [CNT_W-1:0] preset_reg, count_reg;
      logic [1:0]       state_reg;
      logic             sel, wr_ctrl, wr_preset;
      logic             en_eff, mode_eff, hw_set;
      logic [31:0]      preset_ext, count_ext;

      assign sel       = (addr[6:4] == 3'(gi));
      assign wr_ctrl   = we && sel && (addr[3:2] == R_CTRL);
      assign wr_preset = we && sel && (addr[3:2] == R_PRESET);

      // The FSM sees the control value in force after this edge, so a bus
      // write of EN/MODE acts on the same edge it is written.
      assign en_eff   = wr_ctrl ? wdata[0] : en_reg;
      assign mode_eff = wr_ctrl ? wdata[1] : mode_reg;
      assign hw_set   = (state_reg == ST_CNT) && en_eff && !(count_reg > CNT_W'(1));

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          en_reg     <= 1'b0;
          mode_reg   <= 1'b0;
          im_reg     <= 1'b0;
          pend_reg   <= 1'b0;
          preset_reg <= '0;
          count_reg  <= '0;
          state_reg  <= ST_IDLE;
        end else begin
          if (wr_ctrl) begin
            en_reg   <= wdata[0];
            mode_reg <= wdata[1];
            im_reg   <= wdata[2];
          end else if (state_reg == ST_INT && !mode_reg) begin
            en_reg <= 1'b0;
          end
          // Hardware set beats a simultaneous write-1-to-clear.
          pend_reg <= hw_set | (pend_reg & ~(wr_ctrl & wdata[3]));
          if (wr_preset) preset_reg <= wdata[CNT_W-1:0];

          case (state_reg)
            ST_IDLE: if (en_eff) state_reg <= ST_LOAD;
            ST_LOAD: begin
              count_reg <= (preset_reg == '0) ? CNT_W'(1) : preset_reg;
              state_reg <= ST_CNT;
            end
            ST_CNT: begin
              if (!en_eff) begin
                state_reg <= ST_IDLE;
              end else if (count_reg > CNT_W'(1)) begin
                count_reg <= count_reg - CNT_W'(1);
              end else begin
                count_reg <= '0;
                state_reg <= ST_INT;
              end
            end
            default: state_reg <= (mode_eff && en_eff) ? ST_LOAD : ST_IDLE;
          endcase
        end
      end

      always_comb begin
        preset_ext = '0;
        preset_ext[CNT_W-1:0] = preset_reg;
        count_ext = '0;
        count_ext[CNT_W-1:0] = count_reg;
        case (addr[3:2])
          R_CTRL:   rd_ch[gi] = {28'd0, pend_reg, im_reg, mode_reg, en_reg};
          R_PRESET: rd_ch[gi] = preset_ext;
          R_COUNT:  rd_ch[gi] = count_ext;
          default:  rd_ch[gi] = '0;
        endcase
      end

      assign irq[gi] = pend_reg & im_reg;
    end
  endgenerate

  // Channel indices at or above N_CH fall through to zero.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (addr[6:4] == 3'(i)) rdata = rd_ch[i];
    end
  end

  assign irq_any = |irq;

endmodule

// File: tb/tb_timer_array.sv
// Directed bench for timer_array with N_CH=4, CNT_W=8; expected values are
// hand-derived from the channel timing (load one edge after EN, PEND after P more).
module tb_timer_array;

  logic        clk;
  logic        reset;
  logic [7:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [3:0]  irq;
  logic        irq_any;

  int n_checks = 0;
  int n_errors = 0;

  timer_array #(.N_CH(4), .CNT_W(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .addr    (addr),
    .we      (we),
    .wdata   (wdata),
    .rdata   (rdata),
    .irq     (irq),
    .irq_any (irq_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  function automatic logic [7:0] a_of(input int c, input int r);
    return 8'(c * 16 + r * 4);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int c, input int r, input logic [31:0] d);
    addr  = a_of(c, r);
    wdata = d;
    we    = 1'b1;
    @(posedge clk);
    #1;
    we    = 1'b0;
    $display("wr   ch%0d reg%0d <= 0x%0h", c, r, d);
  endtask

  task automatic rchk(input string tag, input int c, input int r, input logic [31:0] exp);
    addr = a_of(c, r);
    #1;
    check(tag, rdata, exp);
  endtask

  initial begin
    reset = 1'b0;
    we    = 1'b0;
    addr  = '0;
    wdata = '0;
    tick();
    tick();
    rchk("rst_ctrl0", 0, 0, 32'h0);
    check("rst_irq", {28'd0, irq}, 32'h0);
    check("rst_irq_any", {31'd0, irq_any}, 32'h0);
    reset = 1'b1;
    tick();

    // reset asserted while ch0 is mid-count
    wr(0, 1, 32'd5);
    wr(0, 0, 32'h5);
    tick();
    tick();
    tick();
    rchk("pre_rst_count", 0, 2, 32'd3);
    reset = 1'b0;
    #1;
    check("rst_mid_irq", {28'd0, irq}, 32'h0);
    for (int c = 0; c < 4; c++) begin
      rchk($sformatf("rst_mid_ctrl%0d", c), c, 0, 32'h0);
      rchk($sformatf("rst_mid_preset%0d", c), c, 1, 32'h0);
      rchk($sformatf("rst_mid_count%0d", c), c, 2, 32'h0);
      tick();
    end
    reset = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    rchk("post_rst_count", 0, 2, 32'h0);
    rchk("post_rst_ctrl", 0, 0, 32'h0);

    // one-shot ch0, PRESET=3
    wr(0, 1, 32'd3);
    wr(0, 0, 32'h5);
    check("os_irq_e0", {28'd0, irq}, 32'h0);
    tick(); rchk("os_count_e1", 0, 2, 32'd3);
    tick(); rchk("os_count_e2", 0, 2, 32'd2);
    tick(); rchk("os_count_e3", 0, 2, 32'd1);
    check("os_irq_e3", {28'd0, irq}, 32'h0);
    tick(); rchk("os_count_e4", 0, 2, 32'd0);
    check("os_irq_e4", {28'd0, irq}, 32'h1);
    tick(); rchk("os_ctrl_e5", 0, 0, 32'hC);
    tick(); tick();
    check("os_irq_hold", {28'd0, irq}, 32'h1);
    wr(0, 0, 32'hC);
    rchk("os_ctrl_clr", 0, 0, 32'h4);
    check("os_irq_clr", {28'd0, irq}, 32'h0);

    // auto-reload ch1, PRESET=2: PEND sets every 4 edges
    wr(1, 1, 32'd2);
    wr(1, 0, 32'h7);
    tick();
    tick(); rchk("ar_ctrl_e2", 1, 0, 32'h7);
    tick(); rchk("ar_ctrl_e3", 1, 0, 32'hF);
    check("ar_irq_e3", {28'd0, irq}, 32'h2);
    wr(1, 0, 32'hF);
    rchk("ar_clr_e4", 1, 0, 32'h7);
    tick();
    tick(); rchk("ar_ctrl_e6", 1, 0, 32'h7);
    tick(); rchk("ar_ctrl_e7", 1, 0, 32'hF);
    wr(1, 0, 32'hF);
    rchk("ar_clr_e8", 1, 0, 32'h7);
    tick();
    tick(); rchk("ar_ctrl_e10", 1, 0, 32'h7);
    wr(1, 0, 32'hF);
    rchk("ar_set_wins_e11", 1, 0, 32'hF);
    wr(1, 0, 32'h8);
    rchk("ar_stop_ctrl", 1, 0, 32'h0);
    tick(); tick(); tick(); tick(); tick();
    rchk("ar_stopped_ctrl", 1, 0, 32'h0);
    check("ar_stopped_irq", {28'd0, irq}, 32'h0);

    // mask / aggregation: ch0 IM=1, ch2 IM=0
    wr(0, 1, 32'd2);
    wr(2, 1, 32'd2);
    wr(0, 0, 32'h5);
    wr(2, 0, 32'h1);
    tick();
    tick(); check("mask_irq_e3", {28'd0, irq}, 32'h1);
    tick(); check("mask_irq_e4", {28'd0, irq}, 32'h1);
    check("mask_irq_any", {31'd0, irq_any}, 32'h1);
    tick(); rchk("mask_ctrl2", 2, 0, 32'h8);
    wr(0, 0, 32'h8);
    wr(2, 0, 32'h8);
    check("mask_irq_any_clr", {31'd0, irq_any}, 32'h0);

    // PRESET rewritten mid-count does not shorten the current period
    wr(0, 1, 32'd6);
    wr(0, 0, 32'h5);
    tick(); rchk("mid_count_e1", 0, 2, 32'd6);
    wr(0, 1, 32'd10);
    rchk("mid_count_e2", 0, 2, 32'd5);
    rchk("mid_preset", 0, 1, 32'd10);
    tick(); tick(); tick();
    tick(); rchk("mid_count_e6", 0, 2, 32'd1);
    rchk("mid_ctrl_e6", 0, 0, 32'h5);
    tick(); rchk("mid_ctrl_e7", 0, 0, 32'hD);
    wr(0, 0, 32'h8);
    rchk("mid_ctrl_clr", 0, 0, 32'h0);

    // EN=0 written while COUNT reads 4 freezes it
    wr(0, 1, 32'd6);
    wr(0, 0, 32'h1);
    tick(); tick(); tick();
    rchk("frz_count_e3", 0, 2, 32'd4);
    wr(0, 0, 32'h0);
    rchk("frz_count_e4", 0, 2, 32'd4);
    for (int k = 0; k < 8; k++) tick();
    rchk("frz_count_hold", 0, 2, 32'd4);
    rchk("frz_ctrl", 0, 0, 32'h0);

    // decode edges
    wr(5, 0, 32'h7);
    wr(5, 1, 32'h33);
    rchk("dec_ch5_ctrl", 5, 0, 32'h0);
    rchk("dec_ch5_preset", 5, 1, 32'h0);
    rchk("dec_ch1_ctrl", 1, 0, 32'h0);
    tick();
    rchk("dec_ch1_preset", 1, 1, 32'd2);
    wr(0, 3, 32'hFF);
    rchk("dec_reg3", 0, 3, 32'h0);
    rchk("dec_reg3_ctrl0", 0, 0, 32'h0);
    wr(0, 2, 32'h55);
    rchk("dec_count_ro", 0, 2, 32'd4);
    rchk("dec_preset0", 0, 1, 32'd6);
    wr(3, 1, 32'h1FF);
    rchk("dec_preset_trunc", 3, 1, 32'hFF);

    // PRESET=0 runs as PRESET=1
    wr(3, 1, 32'd0);
    wr(3, 0, 32'h5);
    tick(); rchk("p0_count_e1", 3, 2, 32'd1);
    check("p0_irq_e1", {28'd0, irq}, 32'h0);
    tick(); check("p0_irq_e2", {28'd0, irq}, 32'h8);
    rchk("p0_count_e2", 3, 2, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/timer_array.md
# timer_array

Parametrised successor to the two fixed memory-mapped timers: one block holding `N_CH` independent down-counting timer channels behind a single bridge-side register port. Each channel has one-shot and auto-reload modes, a per-channel interrupt mask and a sticky write-1-to-clear pending flag. Per-channel `irq` lines and their OR feed the CPU hardware-interrupt vector. The block sits behind the system bridge in place of the discrete timer instances.

## Interface
- `N_CH`, default 2: number of channels, legal range 1..8.
- `CNT_W`, default 32: counter/preset width, legal range 8..32; read data is zero-extended to 32 bits.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `addr`  in  8  byte offset within the block. `addr[6:4]` selects the channel, `addr[3:2]` selects the register, `addr[1:0]` is ignored.
- `we`  in  1  write strobe, one cycle per write.
- `wdata`  in  32  write data.
- `rdata`  out  32  combinational read data for `addr`.
- `irq`  out  N_CH  per-channel interrupt, `pending & IM`.
- `irq_any`  out  1  OR of `irq`.

## Operation
- Per-channel registers, selected by `addr[3:2]`:
  - 0 = CTRL: bit0 EN, bit1 MODE (0 one-shot, 1 auto-reload), bit2 IM, bit3 PEND. Other bits read 0.
  - 1 = PRESET: `CNT_W` bits, read/write.
  - 2 = COUNT: read-only; writes are ignored.
  - 3: reads 0, writes ignored.
- A channel index ≥ `N_CH` reads 0 and ignores writes.
- CTRL write: EN, MODE and IM take `wdata[2:0]`. `wdata[3]`=1 clears PEND; `wdata[3]`=0 leaves PEND unchanged.
- Per-channel FSM:
  - IDLE: if EN, go to LOAD.
  - LOAD: COUNT <= PRESET, go to CNT. A PRESET of 0 is loaded as 1.
  - CNT: if EN=0, go to IDLE and hold COUNT. Else if COUNT > 1, COUNT <= COUNT-1. Else COUNT <= 0, PEND <= 1, go to INT.
  - INT, one cycle: if MODE=0, EN <= 0 and go to IDLE. If MODE=1 and EN=1, go to LOAD. If EN=0, go to IDLE.
- A PRESET write during CNT does not affect COUNT until the next LOAD.
- Simultaneous hardware PEND set and bus W1C on the same edge: the set wins, so PEND=1.
- Simultaneous hardware EN clear (one-shot INT) and a bus CTRL write on the same edge: the bus value wins.
- Channels are fully independent; a write affects only the addressed channel.
- Reset, asynchronous: every CTRL/PRESET/COUNT = 0, all FSMs IDLE, `irq`=0, `irq_any`=0. `rdata` then reflects zeroed registers, so 0 for any address.
- Reset asserted mid-count aborts immediately. After release the channel stays IDLE until EN is written.

## Timing
- Writes take effect on the edge where `we`=1. Reads are zero-latency (combinational from `addr` and state).
- With EN written at edge e0: LOAD at e1, CNT during edges e2..e(P+1) for PRESET=P≥1, PEND set and INT entered at e(P+1).
- `irq` rises in the cycle after e(P+1), so P+1 cycles after the EN write.
- Auto-reload period between PEND sets: P+2 cycles.
- `irq`/`irq_any` are registered-state-derived: no combinational path from `wdata`/`we`, except through PEND/IM registers updated at the edge.
- `irq` stays high until PEND is cleared by W1C or IM is cleared; the INT state does not drop it.

## Test plan
- Reset: hold `reset`=0 mid-count on ch0 with PRESET=5 → all `rdata` reads 0 and `irq`=0. After release, COUNT stays 0 and the state stays IDLE for 10 cycles.
- One-shot ch0: PRESET=3, CTRL=0b101 → COUNT reads 3,2,1,0. `irq[0]` rises 4 cycles after the CTRL write, CTRL then reads 0b1100, and `irq` holds until CTRL is written with bit3=1.
- Auto-reload ch1 (N_CH=4): PRESET=2, CTRL=0b111 → PEND sets every 4 cycles. Clearing PEND the same cycle as a reload re-set leaves PEND=1.
- Mask/aggregation: ch0 and ch2 both expire with IM0=1 and IM2=0 → `irq`=4'b0001, `irq_any`=1, ch2 CTRL reads PEND=1.
- Mid-count changes: write PRESET=10 while ch0 counts from 6 → the current period still expires after 6. Writing EN=0 at COUNT=4 freezes COUNT at 4 with no PEND.
- Decode edges: write to channel 5 with N_CH=4, to register 3, and to COUNT → no register changes and reads return 0. PRESET=0 behaves as PRESET=1 with `CNT_W`=8.
